// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR definitions for generator and checker.
// Holds the width, tap mask, checker state enum and step function.
package lfsr_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } state_e;

   // Shift left, feedback = XOR of taps 7,5,4,3 (maximal length).
   function automatic logic [LFSR_W-1:0] lfsr_next(
      input logic [LFSR_W-1:0] q
   );
      return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto an 8-bit LFSR stream and counts errors.
// Ports: clk, rst (async active-low), data_in/data_valid (sample),
// err_clr (sync clear), locked, error (pulse), err_count (saturating).
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned UNLOCK_ERRS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LFSR_W-1:0] data_in,
   input  logic              data_valid,
   input  logic              err_clr,
   output logic              locked,
   output logic              error,
   output logic [15:0]       err_count
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] UNLK_N = 4'(UNLOCK_ERRS);

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] pred_q, pred_d;
   logic [3:0]        good_q, good_d;
   logic [3:0]        bad_q, bad_d;
   logic              locked_q, locked_d;
   logic              error_q, error_d;
   logic [15:0]       err_cnt_q, err_cnt_d;

   logic       hit;
   logic       nz;
   logic       miss_lk;
   logic [3:0] good_inc;
   logic [3:0] bad_inc;

   assign hit      = (data_in == pred_q);
   assign nz       = |data_in;
   assign good_inc = good_q + 4'd1;
   assign bad_inc  = bad_q + 4'd1;
   assign miss_lk  = data_valid && (state_q == LOCKED) && !hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= HUNT;
         pred_q    <= '0;
         good_q    <= '0;
         bad_q     <= '0;
         locked_q  <= 1'b0;
         error_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pred_q    <= pred_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         locked_q  <= locked_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (data_valid) begin
         unique case (state_q)
            HUNT: begin
               if (nz) state_d = VERIFY;
            end
            VERIFY: begin
               if (hit) begin
                  if (good_inc == LOCK_N) state_d = LOCKED;
               end else if (!nz) begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (!hit && bad_inc == UNLK_N) state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      pred_d    = pred_q;
      good_d    = good_q;
      bad_d     = bad_q;
      error_d   = 1'b0;
      err_cnt_d = err_cnt_q;
      if (data_valid) begin
         unique case (state_q)
            HUNT: begin
               if (nz) begin
                  pred_d = lfsr_next(data_in);
                  good_d = '0;
               end
            end
            VERIFY: begin
               pred_d = lfsr_next(data_in);
               good_d = hit ? good_inc : 4'd0;
               if (hit && good_inc == LOCK_N) bad_d = '0;
            end
            LOCKED: begin
               // Flywheel: never reseed from the line once locked.
               pred_d  = lfsr_next(pred_q);
               bad_d   = hit ? 4'd0 : bad_inc;
               error_d = !hit;
            end
            default: ;
         endcase
      end
      // A clear coinciding with a counted miss leaves that miss counted.
      if (err_clr) begin
         err_cnt_d = {15'd0, miss_lk};
      end else if (miss_lk && err_cnt_q != 16'hFFFF) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   assign locked_d = (state_d == LOCKED);

   assign locked    = locked_q;
   assign error     = error_q;
   assign err_count = err_cnt_q;

endmodule
